output_mems: RTL and testbench
==============================

OUTPUT_MEMS -- requirements
Module: output_mems

Interface
REQ-001 Parameter OUTW, default 28, width of one result word of C.
REQ-002 Parameter M, default 7, rows of C.
REQ-003 Parameter N, default 9, columns of C.
REQ-004 Derived constant C_ADDR_BITS = $clog2(M*N); not overridable.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 C_wr_en  input  1  compute engine writes one C word this cycle.
REQ-008 C_wr_addr  input  C_ADDR_BITS  row-major C index (row*N+col).
REQ-009 C_data  input  OUTW  signed C word to store.
REQ-010 compute_done  input  1  single-cycle pulse: all of C has been written.
REQ-011 out_ready  output  1  high while the block accepts C writes.
REQ-012 AXIS_TDATA  output  OUTW  streamed C word.
REQ-013 AXIS_TVALID  output  1  AXIS_TDATA holds a valid word.
REQ-014 AXIS_TREADY  input  1  downstream accepts the word this cycle.
REQ-015 AXIS_TLAST  output  1  high with the final word, index M*N-1.

Function
REQ-016 States: FILL and DRAIN only; reset enters FILL.
REQ-017 FILL: out_ready=1; on C_wr_en with C_wr_addr < M*N, store C_data at C_wr_addr; writes with addresses >= M*N are dropped.
REQ-018 FILL: compute_done=1 moves to DRAIN next cycle; a write in the same cycle as compute_done is committed and is streamed.
REQ-019 DRAIN: out_ready=0; C_wr_en and compute_done are ignored; memory contents unchanged.
REQ-020 DRAIN streams indices 0..M*N-1 in ascending order, each exactly once; a beat transfers on TVALID&&TREADY.
REQ-021 First AXIS_TVALID rises no later than 2 cycles after the cycle compute_done is sampled.
REQ-022 With TREADY held high, one beat transfers every cycle after the first; no bubbles.
REQ-023 While TVALID=1 and TREADY=0, TDATA, TLAST and TVALID hold stable.
REQ-024 TVALID never depends combinationally on TREADY; TVALID does not drop until its beat transfers.
REQ-025 TLAST=1 only on the beat carrying index M*N-1, otherwise 0.
REQ-026 After the TLAST handshake, TVALID=0 and state=FILL the next cycle (out_ready=1).
REQ-027 TDATA carries the stored bits unchanged, sign included.
REQ-028 Memory read latency is one cycle; the 1-cycle latency and REQ-022/023 are met with a 2-entry output skid buffer; no combinational memory read.

Reset
REQ-029 On reset: state=FILL, out_ready=1, AXIS_TVALID=0, AXIS_TLAST=0, AXIS_TDATA=0, read index and skid buffer cleared.
REQ-030 Reset mid-DRAIN aborts the stream: TVALID=0 the cycle after reset is sampled; no partial resume.
REQ-031 Memory array is not cleared by reset; unwritten locations stream undefined-but-stable data.

Structure
REQ-032 Package output_mems_pkg holds the state enum (FILL, DRAIN) and default OUTW/M/N constants, shared with the compute engine.
REQ-033 One sub-module: out_memory, single-port synchronous RAM, depth M*N, width OUTW, 1-cycle registered read, write-enable port.
REQ-034 The state register, read-index counter and skid buffer live in output_mems; no other sub-modules.

Verification (defaults M=7, N=9, OUTW=28)
REQ-035 Write C[i]=i+1 for i=0..62, pulse compute_done, TREADY=1 -> 63 beats 1..63 on consecutive cycles, TLAST only on 63, out_ready=1 the cycle after.
REQ-036 Same fill; TREADY pattern 1,0,0,1 repeating -> identical sequence 1..63, no duplicate or drop, TDATA/TLAST stable on every stall cycle.
REQ-037 Write all 63 words as -1 (all ones) -> every TDATA = 28'hFFFFFFF.
REQ-038 Write index 62 = 0x5A in the same cycle as compute_done -> final TLAST beat carries 0x5A.
REQ-039 Reset after the 10th beat -> TVALID=0 next cycle, out_ready=1; new fill+compute_done restarts from index 0.
REQ-040 During DRAIN drive C_wr_en, addr 0, data 999, plus an extra compute_done -> ignored; stream unchanged, exactly 63 beats.

Source files
------------

// File: rtl/output_mems_pkg.sv
// Types and default dimensions for the C result buffer.
// The compute engine shares these definitions with output_mems.
package output_mems_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int OUTW_DEF = 28;
  localparam int M_DEF    = 7;
  localparam int N_DEF    = 9;

endpackage

// File: rtl/out_memory.sv
// Single-port synchronous RAM holding the C matrix.
// Registered read with one cycle of latency; a write and a read share the address.
module out_memory #(
  parameter  int OUTW      = 28,
  parameter  int DEPTH     = 63,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic signed [OUTW-1:0] wdata,
  output logic signed [OUTW-1:0] rdata
);

  logic signed [OUTW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/output_mems.sv
// Buffers the C matrix written by the compute engine, then streams it row-major
// over AXI-Stream through a 2-entry skid buffer that hides the RAM read latency.
module output_mems
  import output_mems_pkg::*;
#(
  parameter  int OUTW        = OUTW_DEF,
  parameter  int M           = M_DEF,
  parameter  int N           = N_DEF,
  localparam int C_ADDR_BITS = $clog2(M * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_wr_en,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic signed [OUTW-1:0] C_data,
  input  logic                   compute_done,
  output logic                   out_ready,
  output logic signed [OUTW-1:0] AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  localparam int DEPTH = M * N;
  localparam logic [C_ADDR_BITS:0] DEPTH_W  = (C_ADDR_BITS + 1)'(DEPTH);
  localparam logic [C_ADDR_BITS:0] LAST_IDX = (C_ADDR_BITS + 1)'(DEPTH - 1);

  state_t                 state;
  logic [C_ADDR_BITS:0]   rd_idx_p0;
  logic                   issue_p0;
  logic                   vld_p1;
  logic                   last_p1;

  logic signed [OUTW-1:0] skid_data [2];
  logic                   skid_last [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             cnt;

  logic                   mem_we;
  logic [C_ADDR_BITS-1:0] mem_addr;
  logic signed [OUTW-1:0] mem_rdata;

  logic                   pop;
  logic                   drain_done;
  logic [1:0]             occ;

  out_memory #(
    .OUTW  (OUTW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (C_data),
    .rdata (mem_rdata)
  );

  assign out_ready   = (state == FILL);
  assign AXIS_TVALID = (cnt != 2'd0);
  assign AXIS_TDATA  = skid_data[rd_ptr];
  assign AXIS_TLAST  = AXIS_TVALID && skid_last[rd_ptr];

  // Issue a read only when the buffer plus the in-flight word still fits after this cycle's pop.
  always_comb begin
    mem_we     = (state == FILL) && C_wr_en && ({1'b0, C_wr_addr} < DEPTH_W);
    mem_addr   = (state == DRAIN) ? rd_idx_p0[C_ADDR_BITS-1:0] : C_wr_addr;
    pop        = AXIS_TVALID && AXIS_TREADY;
    drain_done = pop && AXIS_TLAST;
    occ        = cnt + {1'b0, vld_p1};
    issue_p0   = (state == DRAIN) && (rd_idx_p0 < DEPTH_W) && (occ < (2'd2 + {1'b0, pop}));
  end

  // p0 -> p1: read address issued, RAM output valid next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      rd_idx_p0 <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          vld_p1    <= 1'b0;
          last_p1   <= 1'b0;
          rd_idx_p0 <= '0;
          if (compute_done) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          vld_p1  <= issue_p0;
          last_p1 <= issue_p0 && (rd_idx_p0 == LAST_IDX);
          if (issue_p0) begin
            rd_idx_p0 <= rd_idx_p0 + 1'b1;
          end
          if (drain_done) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // p1 -> skid buffer: capture RAM output, present head to the stream
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_data[0] <= '0;
      skid_data[1] <= '0;
      skid_last[0] <= 1'b0;
      skid_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      cnt          <= 2'd0;
    end else begin
      if (vld_p1) begin
        skid_data[wr_ptr] <= mem_rdata;
        skid_last[wr_ptr] <= last_p1;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_output_mems.sv
// Directed bench for output_mems: fill C, stream it out, compare against a table.
module tb_output_mems;

  localparam int OUTW = 28;
  localparam int M    = 7;
  localparam int N    = 9;
  localparam int MN   = M * N;
  localparam int AB   = $clog2(MN);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   C_wr_en;
  logic [AB-1:0]          C_wr_addr;
  logic signed [OUTW-1:0] C_data;
  logic                   compute_done;
  logic                   out_ready;
  logic signed [OUTW-1:0] AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic                   AXIS_TREADY;
  logic                   AXIS_TLAST;
  logic [OUTW-1:0]        tdata_u;

  logic [OUTW-1:0]        exp_mem [MN];
  int                     n_checks = 0;
  int                     n_fail   = 0;

  assign tdata_u = AXIS_TDATA;

  output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .C_wr_en      (C_wr_en),
    .C_wr_addr    (C_wr_addr),
    .C_data       (C_data),
    .compute_done (compute_done),
    .out_ready    (out_ready),
    .AXIS_TDATA   (AXIS_TDATA),
    .AXIS_TVALID  (AXIS_TVALID),
    .AXIS_TREADY  (AXIS_TREADY),
    .AXIS_TLAST   (AXIS_TLAST)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Writes exp_mem into the DUT; compute_done either shares the last write or follows it.
  task automatic fill(input bit done_with_last);
    @(negedge clk);
    check("fill_out_ready", out_ready, 1);
    C_wr_en   = 1'b1;
    C_wr_addr = AB'(MN);
    C_data    = 28'sh0123;
    for (int i = 0; i < MN; i++) begin
      @(negedge clk);
      C_wr_en      = 1'b1;
      C_wr_addr    = AB'(i);
      C_data       = signed'(exp_mem[i]);
      compute_done = done_with_last && (i == MN - 1);
    end
    if (!done_with_last) begin
      @(negedge clk);
      C_wr_en      = 1'b0;
      compute_done = 1'b1;
    end
    @(negedge clk);
    C_wr_en      = 1'b0;
    compute_done = 1'b0;
    check("drain_out_ready", out_ready, 0);
  endtask

  // mode 0: TREADY held high; mode 1: TREADY pattern 1,0,0,1.
  task automatic drain(input int mode, input int stop_after, input bit inject);
    int   idx = 0;
    int   first_v = 0;
    int   last_cyc = 0;
    bit   prev_stall = 1'b0;
    bit   tr;
    logic [OUTW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    for (int cyc = 1; cyc <= 400 && idx < stop_after; cyc++) begin
      @(negedge clk);
      tr = (mode == 0) ? 1'b1 : ((cyc % 4) == 1 || (cyc % 4) == 0);
      if (inject && cyc >= 5 && cyc <= 8) begin
        C_wr_en      = 1'b1;
        C_wr_addr    = '0;
        C_data       = 28'sd999;
        compute_done = (cyc == 6);
      end else begin
        C_wr_en      = 1'b0;
        compute_done = 1'b0;
      end
      if (AXIS_TVALID && first_v == 0) begin
        first_v = cyc;
        check("first_valid_latency_ok", (cyc <= 2), 1);
      end
      if (prev_stall) begin
        check("stall_tvalid", AXIS_TVALID, 1);
        check("stall_tdata", tdata_u, prev_d);
        check("stall_tlast", AXIS_TLAST, prev_l);
      end
      AXIS_TREADY = tr;
      if (AXIS_TVALID && tr) begin
        check("beat_data", tdata_u, exp_mem[idx]);
        check("beat_tlast", AXIS_TLAST, (idx == MN - 1));
        if (mode == 0 && idx > 0) check("no_bubble", cyc, last_cyc + 1);
        last_cyc = cyc;
        idx++;
      end
      prev_stall = AXIS_TVALID && !tr;
      prev_d     = tdata_u;
      prev_l     = AXIS_TLAST;
    end
    check("beat_count", idx, stop_after);
    C_wr_en      = 1'b0;
    compute_done = 1'b0;
  endtask

  task automatic after_stream();
    @(negedge clk);
    check("end_tvalid", AXIS_TVALID, 0);
    check("end_tlast", AXIS_TLAST, 0);
    check("end_out_ready", out_ready, 1);
  endtask

  initial begin
    reset        = 1'b1;
    C_wr_en      = 1'b0;
    C_wr_addr    = '0;
    C_data       = '0;
    compute_done = 1'b0;
    AXIS_TREADY  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_ready", out_ready, 1);
    check("rst_tvalid", AXIS_TVALID, 0);
    check("rst_tlast", AXIS_TLAST, 0);
    check("rst_tdata", tdata_u, 0);
    reset = 1'b0;

    // Ascending fill, full-rate drain
    for (int i = 0; i < MN; i++) exp_mem[i] = OUTW'(i + 1);
    fill(1'b0);
    drain(0, MN, 1'b0);
    after_stream();

    // Same data under back-pressure
    fill(1'b0);
    drain(1, MN, 1'b0);
    after_stream();

    // All-ones words keep every bit
    for (int i = 0; i < MN; i++) exp_mem[i] = '1;
    fill(1'b0);
    drain(0, MN, 1'b0);
    after_stream();

    // Final word written in the compute_done cycle
    for (int i = 0; i < MN; i++) exp_mem[i] = OUTW'(i + 1);
    exp_mem[MN-1] = 28'h5A;
    fill(1'b1);
    drain(0, MN, 1'b0);
    after_stream();

    // Reset aborts a stream after 10 beats, then a fresh run starts at index 0
    for (int i = 0; i < MN; i++) exp_mem[i] = OUTW'(i + 1);
    fill(1'b0);
    drain(0, 10, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tvalid", AXIS_TVALID, 0);
    check("abort_out_ready", out_ready, 1);
    fill(1'b0);
    drain(0, MN, 1'b0);
    after_stream();

    // Writes and compute_done during drain are ignored
    fill(1'b0);
    drain(0, MN, 1'b1);
    after_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
